// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store + writeback stage:
// memory-op encodings, FSM state type and lane/extension helpers.
package lsu_pkg;

  localparam int XLEN    = 32;
  localparam int MEMOP_W = 4;

  typedef logic [MEMOP_W-1:0] memop_t;

  localparam memop_t MEMOP_NONE = 4'd0;
  localparam memop_t MEMOP_LB   = 4'd1;
  localparam memop_t MEMOP_LH   = 4'd2;
  localparam memop_t MEMOP_LW   = 4'd3;
  localparam memop_t MEMOP_LBU  = 4'd4;
  localparam memop_t MEMOP_LHU  = 4'd5;
  localparam memop_t MEMOP_SB   = 4'd6;
  localparam memop_t MEMOP_SH   = 4'd7;
  localparam memop_t MEMOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  function automatic logic is_load(memop_t op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LHU);
  endfunction

  function automatic logic is_store(memop_t op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic misaligned(memop_t op, logic [1:0] lane);
    logic m;
    m = 1'b0;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: m = lane[0];
      MEMOP_LW, MEMOP_SW:            m = (lane != 2'b00);
      default:                       m = 1'b0;
    endcase
    return m;
  endfunction

  // Select the addressed byte/half from the raw word and extend it.
  function automatic logic [XLEN-1:0] load_extend(memop_t op, logic [1:0] lane,
                                                  logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEMOP_LB:  r = {{24{b[7]}}, b};
      MEMOP_LBU: r = {24'd0, b};
      MEMOP_LH:  r = {{16{h[15]}}, h};
      MEMOP_LHU: r = {16'd0, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replicate store data across lanes and build the byte strobes: {wdata, wmask}.
  function automatic logic [XLEN+3:0] store_lane(memop_t op, logic [1:0] lane,
                                                 logic [XLEN-1:0] data);
    logic [XLEN-1:0] wd;
    logic [3:0]      wm;
    case (op)
      MEMOP_SB: begin
        wd = {4{data[7:0]}};
        wm = 4'b0001 << lane;
      end
      MEMOP_SH: begin
        wd = {2{data[15:0]}};
        wm = lane[1] ? 4'b1100 : 4'b0011;
      end
      MEMOP_SW: begin
        wd = data;
        wm = 4'b1111;
      end
      default: begin
        wd = '0;
        wm = 4'b0000;
      end
    endcase
    return {wd, wm};
  endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Data-memory port of the load/store stage.
// Handshake: the request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; while valid is high and ready is low the
// master keeps address, wen, wdata and wmask stable. mem_rsp_valid is a
// single-cycle response/ack that carries mem_rdata and has no ready.
interface lsu_wb_if;
  import lsu_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extension and store lane/mask generation.
module lsu_align
  import lsu_pkg::*;
(
  input  memop_t          op,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wmask
);

  assign load_val       = load_extend(op, lane, rdata);
  assign {wdata, wmask} = store_lane(op, lane, store_data);

endmodule

// File: rtl/lsu_wb.sv
// Load/store + writeback stage. Accepts one instruction at a time from EX,
// runs an optional data-memory transaction and commits to the register file
// in a single WB cycle.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip memory and report through the misalign output in their WB cycle.
module lsu_wb
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_store_data,
  input  memop_t          in_mem_op,
  lsu_wb_if.master        mem,
  output logic            RegWEn,
  output logic [4:0]      addr_towrite,
  output logic [XLEN-1:0] data_towrite,
  output logic            wb_done,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output lsu_state_e      state_dbg
);

  lsu_state_e      state, state_next;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] result_q;
  memop_t          op_q;
  logic            trap_q;

  memop_t          in_op;
  logic            in_trap;
  logic            accept;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wmask;

  // Unknown encodings collapse to NONE at the door.
  assign in_op  = (in_mem_op > MEMOP_SW) ? MEMOP_NONE : in_mem_op;
  assign accept = (state == ST_IDLE) && in_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_trap = misaligned(in_op, in_alu_res[1:0]);
`else
  assign in_trap = 1'b0;
`endif

  lsu_align u_align (
    .op         (op_q),
    .lane       (alu_q[1:0]),
    .rdata      (mem.mem_rdata),
    .store_data (sdata_q),
    .load_val   (load_val),
    .wdata      (st_wdata),
    .wmask      (st_wmask)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Instruction latch on accept; load result captured on the response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      wen_q    <= 1'b0;
      alu_q    <= '0;
      sdata_q  <= '0;
      result_q <= '0;
      op_q     <= MEMOP_NONE;
      trap_q   <= 1'b0;
    end else if (accept) begin
      rd_q     <= in_rd;
      wen_q    <= in_wen;
      alu_q    <= in_alu_res;
      sdata_q  <= in_store_data;
      result_q <= in_alu_res;
      op_q     <= in_op;
      trap_q   <= in_trap;
    end else if (state == ST_RESP && mem.mem_rsp_valid && is_load(op_q)) begin
      result_q <= load_val;
    end
  end

  // Next-state logic; responses only count while waiting in RESP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_op == MEMOP_NONE || in_trap) state_next = ST_WB;
          else                                state_next = ST_REQ;
        end
      end
      ST_REQ:  if (mem.mem_req_ready) state_next = ST_RESP;
      ST_RESP: if (mem.mem_rsp_valid) state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields come straight from the latched instruction, zero when idle.
  assign in_ready          = (state == ST_IDLE);
  assign mem.mem_req_valid = (state == ST_REQ);
  assign mem.mem_addr      = (state == ST_REQ) ? {alu_q[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_wen       = (state == ST_REQ) && is_store(op_q);
  assign mem.mem_wdata     = (state == ST_REQ) ? st_wdata : '0;
  assign mem.mem_wmask     = (state == ST_REQ) ? st_wmask : 4'b0000;

  assign wb_done      = (state == ST_WB);
  assign RegWEn       = wb_done && wen_q && (rd_q != 5'd0) && !is_store(op_q) && !trap_q;
  assign addr_towrite = wb_done ? rd_q : 5'd0;
  assign data_towrite = wb_done ? result_q : '0;
  assign state_dbg    = state;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = wb_done && trap_q;
`endif

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: hand-written vector table, corner-case sequences and
// randomized instructions checked against a behavioural model.
module tb_lsu_wb;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_wen;
  logic [31:0]     in_alu_res;
  logic [31:0]     in_store_data;
  logic [3:0]      in_mem_op;
  logic            RegWEn;
  logic [4:0]      addr_towrite;
  logic [31:0]     data_towrite;
  logic            wb_done;
  logic            misalign_act;
  lsu_state_e      state_dbg;

  lsu_wb_if mem_bus ();

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign_act = misalign;
`else
  assign misalign_act = 1'b0;
`endif

  lsu_wb dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .in_alu_res    (in_alu_res),
    .in_store_data (in_store_data),
    .in_mem_op     (in_mem_op),
    .mem           (mem_bus.master),
    .RegWEn        (RegWEn),
    .addr_towrite  (addr_towrite),
    .data_towrite  (data_towrite),
    .wb_done       (wb_done),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign      (misalign),
`endif
    .state_dbg     (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- vectors and reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    int          stall;
    int          rsp_wait;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic        exp_mwen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic        exp_mis;
    logic        exp_care;
    logic        exp_regwen;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic [31:0] addr, logic [31:0] sdata,
                              logic [31:0] rdata, logic [4:0] rd, logic wen,
                              int stall, int rsp_wait, logic req, logic [31:0] maddr,
                              logic [31:0] wdata, logic [3:0] wmask, logic mis,
                              logic regwen, logic [31:0] data);
    vec_t v;
    logic st;
    st = (op >= 4'd6) && (op <= 4'd8);
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rd = rd; v.wen = wen;
    v.stall = stall; v.rsp_wait = rsp_wait;
    v.exp_req = req; v.exp_maddr = maddr; v.exp_mwen = st;
    v.exp_wdata = wdata; v.exp_wmask = wmask; v.exp_mis = mis;
    v.exp_care = !st && !mis; v.exp_regwen = regwen; v.exp_data = data;
    return v;
  endfunction

  // Expected behaviour straight from the architectural rules, with plain arithmetic.
  function automatic vec_t model(logic [3:0] op, logic [31:0] addr, logic [31:0] sdata,
                                 logic [31:0] rdata, logic [4:0] rd, logic wen,
                                 int stall, int rsp_wait);
    int unsigned lane, eff;
    logic [31:0] b, h, bs, hs, data, wdata;
    logic [3:0]  wmask;
    logic ld, st, mis;
    lane = addr % 4;
    eff  = (op > 8) ? 0 : op;
    ld   = (eff >= 1) && (eff <= 5);
    st   = (eff >= 6) && (eff <= 8);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((eff == 2 || eff == 5 || eff == 7) && (lane % 2 == 1)) ||
          ((eff == 3 || eff == 8) && lane != 0);
`else
    mis = 1'b0;
`endif
    b  = (rdata >> (8 * lane)) & 32'hFF;
    h  = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
    bs = sdata & 32'hFF;
    hs = sdata & 32'hFFFF;
    case (eff)
      1:       data = (b >= 128)   ? b + 32'hFFFFFF00 : b;
      4:       data = b;
      2:       data = (h >= 32768) ? h + 32'hFFFF0000 : h;
      5:       data = h;
      3:       data = rdata;
      default: data = addr;
    endcase
    case (eff)
      6:       begin wdata = bs * 32'h01010101; wmask = 4'(1 << lane); end
      7:       begin wdata = hs * 32'h00010001; wmask = 4'(3 << (2 * (lane / 2))); end
      8:       begin wdata = sdata;             wmask = 4'hF; end
      default: begin wdata = 32'd0;             wmask = 4'h0; end
    endcase
    return mk(op, addr, sdata, rdata, rd, wen, stall, rsp_wait,
              (ld || st) && !mis, addr - lane, wdata, wmask, mis,
              wen && rd != 0 && !st && !mis, data);
  endfunction

  // ---------------- scoreboard ----------------
  // entry = {misalign, care_data, regwen, rd, data}
  logic [39:0] exp_q[$];

  always @(negedge clk) begin
    if (wb_done) begin
      logic [39:0] e;
      logic [31:0] dmask;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 72'(wb_done), 72'(0));
      end else begin
        e = exp_q.pop_front();
        dmask = e[38] ? 32'hFFFF_FFFF : 32'h0;
        check("wb_commit",
              72'({misalign_act, RegWEn, addr_towrite, data_towrite & dmask}),
              72'({e[39], e[37], e[36:32], e[31:0] & dmask}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check({name, "_timeout"}, 72'(in_ready), 72'(1));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    exp_q.push_back({v.exp_mis, v.exp_care, v.exp_regwen, v.rd, v.exp_data});
    wait_ready({name, "_accept"});
    in_valid = 1'b1; in_mem_op = v.op; in_alu_res = v.addr;
    in_store_data = v.sdata; in_rd = v.rd; in_wen = v.wen;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_op = $urandom_range(15, 0); in_alu_res = $urandom();
    if (v.exp_req) begin
      n = 0;
      while (!mem_bus.mem_req_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (!mem_bus.mem_req_valid) begin
        check({name, "_req_timeout"}, 72'(0), 72'(1));
        return;
      end
      check({name, "_req"},
            72'({mem_bus.mem_addr, mem_bus.mem_wen, mem_bus.mem_wdata, mem_bus.mem_wmask}),
            72'({v.exp_maddr, v.exp_mwen, v.exp_wdata, v.exp_wmask}));
      for (int i = 0; i < v.stall; i++) begin
        @(posedge clk); #1;
        check({name, "_req_hold"},
              72'({mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_wen,
                   mem_bus.mem_wdata, mem_bus.mem_wmask}),
              72'({1'b1, v.exp_maddr, v.exp_mwen, v.exp_wdata, v.exp_wmask}));
      end
      mem_bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_bus.mem_req_ready = 1'b0;
      for (int i = 0; i < v.rsp_wait; i++) begin
        mem_bus.mem_rdata = $urandom();
        @(posedge clk); #1;
      end
      mem_bus.mem_rsp_valid = 1'b1;
      mem_bus.mem_rdata     = v.rdata;
      @(posedge clk); #1;
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rdata     = $urandom();
    end else begin
      check({name, "_no_req"}, 72'({mem_bus.mem_req_valid, wb_done}), 72'({1'b0, 1'b1}));
    end
    wait_ready({name, "_done"});
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0;
    in_alu_res = '0; in_store_data = '0; in_mem_op = '0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 72'({in_ready, mem_bus.mem_req_valid, RegWEn, wb_done, state_dbg}),
          72'({1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE}));
    check("rst_wb_bus", 72'({addr_towrite, data_towrite}), 72'(0));
    check("rst_mem_bus", 72'({mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wmask}), 72'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-written table: op, addr, sdata, rdata, rd, wen, stall, wait,
    //                     req, maddr, wdata, wmask, mis, regwen, data
    tbl.push_back(mk(4'd0, 32'h0000_1234, 32'h0, 32'h0, 5, 1, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_1234));
    tbl.push_back(mk(4'd1, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 6, 1, 0, 1,
                     1, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'hFFFF_FF80));
    tbl.push_back(mk(4'd4, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 7, 1, 1, 0,
                     1, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_0080));
    tbl.push_back(mk(4'd7, 32'h8000_0002, 32'hABCD_1234, 32'h0, 9, 1, 3, 2,
                     1, 32'h8000_0000, 32'h1234_1234, 4'b1100, 0, 0, 32'h0));
    tbl.push_back(mk(4'd3, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0,
                     1, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(4'd2, 32'h1000_0002, 32'h0, 32'h8001_7FFF, 8, 1, 0, 0,
                     1, 32'h1000_0000, 32'h0, 4'h0, 0, 1, 32'hFFFF_8001));
    tbl.push_back(mk(4'd5, 32'h1000_0000, 32'h0, 32'h8001_F234, 10, 1, 2, 1,
                     1, 32'h1000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_F234));
    tbl.push_back(mk(4'd6, 32'h2000_0001, 32'h0000_00A5, 32'h0, 11, 1, 0, 0,
                     1, 32'h2000_0000, 32'hA5A5_A5A5, 4'b0010, 0, 0, 32'h0));
    tbl.push_back(mk(4'd8, 32'h2000_0004, 32'hCAFE_F00D, 32'h0, 11, 1, 1, 3,
                     1, 32'h2000_0004, 32'hCAFE_F00D, 4'b1111, 0, 0, 32'h0));
    tbl.push_back(mk(4'd12, 32'h0000_0055, 32'h0, 32'h0, 3, 1, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_0055));
    tbl.push_back(mk(4'd0, 32'h0000_0077, 32'h0, 32'h0, 4, 0, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0000_0077));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(4'd3, 32'h8000_0002, 32'h0, 32'h1122_3344, 12, 1, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0));
    tbl.push_back(mk(4'd7, 32'h4000_0003, 32'h0000_BEEF, 32'h0, 13, 1, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0));
    tbl.push_back(mk(4'd2, 32'h3000_0001, 32'h0, 32'h1234_ABCD, 14, 1, 0, 0,
                     0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0));
`else
    tbl.push_back(mk(4'd3, 32'h8000_0002, 32'h0, 32'h1122_3344, 12, 1, 0, 0,
                     1, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'h1122_3344));
    tbl.push_back(mk(4'd7, 32'h4000_0003, 32'h0000_BEEF, 32'h0, 13, 1, 1, 0,
                     1, 32'h4000_0000, 32'hBEEF_BEEF, 4'b1100, 0, 0, 32'h0));
    tbl.push_back(mk(4'd2, 32'h3000_0001, 32'h0, 32'h1234_ABCD, 14, 1, 0, 0,
                     1, 32'h3000_0000, 32'h0, 4'h0, 0, 1, 32'hFFFF_ABCD));
`endif
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // NONE op: one-cycle WB pulse, in_ready low during WB, idle right after.
    exp_q.push_back({1'b0, 1'b1, 1'b1, 5'd21, 32'h0BAD_F00D});
    wait_ready("lat_accept");
    in_valid = 1'b1; in_mem_op = 4'd0; in_alu_res = 32'h0BAD_F00D; in_rd = 5'd21; in_wen = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_wb", 72'({wb_done, in_ready, state_dbg}), 72'({1'b1, 1'b0, ST_WB}));
    @(posedge clk); #1;
    check("lat_idle", 72'({wb_done, in_ready, RegWEn, state_dbg}),
          72'({1'b0, 1'b1, 1'b0, ST_IDLE}));

    // Stray response while idle must not start a writeback.
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b0;
    check("stray_rsp", 72'({state_dbg, in_ready, wb_done}), 72'({ST_IDLE, 1'b1, 1'b0}));

    // Reset while waiting for a load response; the late response is ignored.
    wait_ready("abort_accept");
    in_valid = 1'b1; in_mem_op = 4'd3; in_alu_res = 32'h8000_0040; in_rd = 5'd9; in_wen = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_req_ready = 1'b0;
    check("abort_in_resp", 72'(state_dbg), 72'(ST_RESP));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b0;
    check("abort_idle", 72'({state_dbg, in_ready, RegWEn, wb_done, mem_bus.mem_req_valid}),
          72'({ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(posedge clk); #1;

    // Randomized instructions against the model.
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic [31:0] a;
      a = $urandom();
      v = model(4'($urandom_range(9, 0)), a, $urandom(), $urandom(),
                5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                $urandom_range(3, 0), $urandom_range(3, 0));
      run_vec(v, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
Load/store + writeback stage of the NPC single-issue core. Sits directly upstream of the general-purpose register file.
- Accepts one executed instruction from EX: ALU result, rd, memory op.
- For loads/stores, runs a valid/ready transaction on the data-memory port, then aligns and sign/zero-extends load data.
- Drives the register file write port (RegWEn, addr_towrite, data_towrite) for exactly one cycle per committing instruction.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
MEMOP_W, 4, width of the memory-op encoding field.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
in_valid  input  1  EX presents an instruction
in_ready  output  1  stage can accept; high only in IDLE
in_rd  input  5  destination register index
in_wen  input  1  instruction writes rd
in_alu_res  input  XLEN  ALU result; memory address for load/store
in_store_data  input  XLEN  rs2 value for stores
in_mem_op  input  MEMOP_W  NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; others treated as NONE
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  XLEN  word-aligned address (low 2 bits zero)
mem_wen  output  1  request is a store
mem_wdata  output  XLEN  store data shifted to byte lane
mem_wmask  output  4  byte strobes
mem_rsp_valid  input  1  response/ack valid (loads and stores)
mem_rdata  input  XLEN  raw read word
RegWEn  output  1  regfile write enable
addr_towrite  output  5  regfile write index
data_towrite  output  XLEN  regfile write data
wb_done  output  1  one-cycle commit pulse (difftest/ebreak hook)

Behaviour:
- Reset: state IDLE. in_ready=1; mem_req_valid=0; RegWEn=0; wb_done=0. addr_towrite and data_towrite are 0; mem_addr, mem_wdata and mem_wmask are 0.
- FSM states: IDLE, REQ, RESP, WB.
- IDLE: on in_valid, latch all inputs.
  - mem_op NONE → WB next cycle (1-cycle latency).
  - Load/store → REQ.
- REQ: mem_req_valid=1. Address, data, mask and wen are held stable until mem_req_ready. On handshake → RESP.
- RESP: wait for mem_rsp_valid, with no timeout. On the response cycle, latch the aligned load result → WB. A store ack → WB, with no register write.
- mem_rsp_valid is ignored outside RESP; a stray response never writes.
- WB: held exactly one cycle, then IDLE.
  - wb_done=1.
  - RegWEn=1 iff latched in_wen && rd!=0 && op is not a store.
  - addr_towrite = rd.
  - data_towrite = load result, or alu_res for NONE.
- Total latency: NONE = 2 cycles from accept to IDLE. Memory op = 4 + request stalls + response wait.
- Byte lane = addr[1:0].
  - LB/LBU: byte at lane, sign/zero-extended to 32.
  - LH/LHU: half at addr[1], extended.
  - LW: full word.
  - SB: wdata = byte replicated ×4, mask = 1<<lane.
  - SH: wdata = half replicated ×2, mask = 4'b0011<<(addr[1]*2).
  - SW: mask 4'b1111.
- Misalignment with the feature off: LH/SH ignore addr[0]; LW/SW ignore addr[1:0].
- Back-to-back: a new instruction is accepted the cycle after WB (IDLE). The WB cycle never asserts in_ready.
- Reset mid-operation (REQ or RESP): return to IDLE and drop the request. A later response is ignored. No RegWEn is produced for the aborted instruction.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign (1 bit). It pulses in a WB-like cycle in place of the memory access when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0.
  - No memory request is issued, RegWEn=0, wb_done=1.
- Undefined: no port; low-bit masking as above.

Decomposition:
- Package lsu_pkg: MEMOP_* encodings, FSM state enum, helper functions load_extend(op, lane, word) and store_lane(op, lane, data) → {wdata, wmask}.
- One natural sub-module: lsu_align (combinational load extend + store lane/mask), instantiated once.

Test Plan:
- ALU op: in_alu_res=0x1234, rd=5, wen=1, op NONE → 1 cycle later RegWEn=1, addr_towrite=5, data_towrite=0x1234, wb_done=1 for one cycle.
- LB at addr 0x80000003, mem_rdata=0x80FF7F01 → mem_addr=0x80000000; data_towrite=0xFFFFFF80. LBU on the same inputs → 0x00000080.
- SH at addr 0x80000002, store_data=0xABCD1234, mem_req_ready low 3 cycles:
  - request held stable throughout;
  - mem_wdata=0x12341234, mem_wmask=4'b1100;
  - after ack, RegWEn=0 and wb_done=1.
- LW to rd=0 with mem_rdata=0xDEADBEEF → wb_done=1, RegWEn=0.
- Reset asserted in RESP, then mem_rsp_valid arrives 2 cycles later → no RegWEn, in_ready=1, state IDLE.
- With LSU_MISALIGN_TRAP_EN: LW at 0x80000002 → mem_req_valid never asserted; misalign=1 and wb_done=1 for one cycle; RegWEn=0.
